csa_calc_dispatcher: RTL and testbench
======================================

Name: csa_calc_dispatcher

Overview:
- Schedules jobs from the AXI register side across NUM_ENGINES parallel csa_calc_logic engines.
- Accepts jobs through a valid/ready port and issues each one to a free engine using round-robin order.
- Collects engine results in round-robin order and presents them one at a time on a result valid/ready port.
- Releases each engine with a one-cycle reset pulse after its result is consumed. Keeps job-issued and job-done counters for status registers.

Parameters:
- AXI_DATA_WIDTH, 32, width of the times/delay config fields and of the status counters.
- CSA_CALC_IN_WIDTH, 40, width of the job input word.
- CSA_CALC_OUT_WIDTH, 48, width of the engine result word.
- NUM_ENGINES, 4, number of attached engines (2..16).
- ENG_IDX_WIDTH, 4, width of the engine index.
- TIMEOUT_CYCLES, 65536, watchdog limit; used only when CSA_DISPATCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_times  in  AXI_DATA_WIDTH  iteration count; latched per job.
- cfg_delay  in  AXI_DATA_WIDTH  delay value; latched per job.
- job_valid  in  1  job offered.
- job_ready  out  1  dispatcher can accept a job this cycle.
- job_in  in  CSA_CALC_IN_WIDTH  job input word.
- res_valid  out  1  result held on res_*.
- res_ready  in  1  consumer accepts the result.
- res_data  out  CSA_CALC_OUT_WIDTH  captured engine output.
- res_engine  out  ENG_IDX_WIDTH  index of the engine that produced the result.
- res_timeout  out  1  result is a watchdog abort.
- eng_inuse  in  NUM_ENGINES  per-engine inuse flag.
- eng_request  out  NUM_ENGINES  one-cycle start pulse per engine.
- eng_times  out  NUM_ENGINES*AXI_DATA_WIDTH  per-engine times, held while the engine is busy.
- eng_delay  out  NUM_ENGINES*AXI_DATA_WIDTH  per-engine delay, held while the engine is busy.
- eng_in  out  NUM_ENGINES*CSA_CALC_IN_WIDTH  per-engine input, held while the engine is busy.
- eng_ready  in  NUM_ENGINES  per-engine done flag; level, held until reset.
- eng_out  in  NUM_ENGINES*CSA_CALC_OUT_WIDTH  per-engine result.
- eng_reset  out  NUM_ENGINES  one-cycle release pulse per engine.
- jobs_issued  out  AXI_DATA_WIDTH  status counter.
- jobs_done  out  AXI_DATA_WIDTH  status counter.

Behaviour:
- Reset values: all outputs 0, including every eng_* slot and both counters. Internal busy mask = 0; dispatch and collect pointers = 0; both FSMs go to their idle state. No pulses are emitted during or after reset.
- Engine k is free when busy[k]=0, eng_inuse[k]=0 and eng_ready[k]=0.
- job_ready is registered: 1 when dispatch FSM is D_IDLE and at least one engine is free.
- Dispatch FSM D_IDLE, job handshake (job_valid && job_ready) at cycle T:
  - Select the first free engine k scanning upward from the dispatch pointer, wrapping modulo NUM_ENGINES.
  - Latch job_in, cfg_times and cfg_delay into slot k. Set busy[k]. Set dispatch pointer = (k+1) mod NUM_ENGINES.
  - Go to D_ISSUE.
- D_ISSUE (cycle T+1): eng_request[k]=1 for exactly one cycle; jobs_issued increments; return to D_IDLE. job_ready is 0 at T+1, so the minimum spacing between accepted jobs is 2 cycles.
- Collect FSM C_SCAN: among engines with busy && eng_ready, pick the first at or after the collect pointer (round-robin). Latch eng_out[k] into res_data and k into res_engine; res_valid=1 next cycle; go to C_HOLD.
- C_HOLD:
  - res_* stay stable until res_valid && res_ready.
  - On that handshake: res_valid=0; eng_reset[k]=1 next cycle for exactly one cycle; busy[k] cleared in that same cycle; jobs_done increments.
  - Collect pointer = (k+1) mod NUM_ENGINES; return to C_SCAN.
- Engine k cannot be re-dispatched while its eng_ready is still high after the reset pulse; the free rule above covers this.
- Simultaneous events: dispatch and collect run independently in the same cycle. They never target the same engine, because dispatch needs busy=0 and collect needs busy=1.
- Counters wrap from 2^AXI_DATA_WIDTH-1 to 0 silently.
- Back-pressure: with res_ready=0, finished engines stay busy. When all engines are busy, job_ready=0.
- eng_inuse rising unexpectedly on a busy engine is ignored.
- rst_n low mid-operation: every output and all state are cleared on the next clock edge. Any pending result is discarded. No eng_reset pulse is issued; engines are reset by their own rst_n.

Optional Feature:
- Macro: CSA_DISPATCH_TIMEOUT_EN.
- Defined:
  - Each busy engine has a cycle counter, cleared when its request pulse is issued.
  - When the counter reaches TIMEOUT_CYCLES without eng_ready, the collect FSM treats the engine as done: res_data=0, res_timeout=1, normal handshake, normal eng_reset pulse.
  - If a timeout and a real eng_ready arrive in the same cycle, the real result wins and res_timeout=0.
- Undefined: no watchdog counters are built; res_timeout is tied to 0.

Test Plan:
- Single job: NUM_ENGINES=4, job_in=40'h1111111111, engine 0 asserts ready 10 cycles after request, res_ready=1 → eng_request[0] one cycle at T+1; res_data equals eng_out[0]; res_engine=0; eng_reset[0] one cycle after the handshake; jobs_issued=jobs_done=1.
- Round-robin fill: 5 back-to-back jobs, engines never finish → requests go to engines 0,1,2,3; job_ready=0 after the fourth; the fifth job is accepted only after some engine is released.
- Result back-pressure: engines 2 and 1 finish in the same cycle, res_ready=0 for 20 cycles → res_* stable throughout; after the handshakes, results come out engine 1 then engine 2 (collect pointer 0); reset pulses follow in the same order.
- Re-dispatch guard: engine 0 keeps eng_ready high for 3 cycles after eng_reset[0] → no eng_request[0] until eng_ready[0]=0.
- Reset mid-operation: rst_n low while 3 engines are busy and res_valid=1 → next cycle every output is 0, job_ready=0 until a free engine is seen, counters=0.
- Timeout (CSA_DISPATCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): engine 3 never asserts ready → result with res_timeout=1, res_data=0, res_engine=3, then eng_reset[3] pulses.

Source files
------------

// File: rtl/csa_calc_dispatcher.sv
// rtl/csa_calc_dispatcher.sv - round-robin job dispatcher/collector for NUM_ENGINES csa_calc_logic engines.
// Optional watchdog abort per engine when CSA_DISPATCH_TIMEOUT_EN is defined.
module csa_calc_dispatcher #(
  parameter int AXI_DATA_WIDTH     = 32,
  parameter int CSA_CALC_IN_WIDTH  = 40,
  parameter int CSA_CALC_OUT_WIDTH = 48,
  parameter int NUM_ENGINES        = 4,
  parameter int ENG_IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES     = 65536
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [AXI_DATA_WIDTH-1:0]                   cfg_times,
  input  logic [AXI_DATA_WIDTH-1:0]                   cfg_delay,
  input  logic                                        job_valid,
  output logic                                        job_ready,
  input  logic [CSA_CALC_IN_WIDTH-1:0]                job_in,
  output logic                                        res_valid,
  input  logic                                        res_ready,
  output logic [CSA_CALC_OUT_WIDTH-1:0]               res_data,
  output logic [ENG_IDX_WIDTH-1:0]                    res_engine,
  output logic                                        res_timeout,
  input  logic [NUM_ENGINES-1:0]                      eng_inuse,
  output logic [NUM_ENGINES-1:0]                      eng_request,
  output logic [NUM_ENGINES*AXI_DATA_WIDTH-1:0]       eng_times,
  output logic [NUM_ENGINES*AXI_DATA_WIDTH-1:0]       eng_delay,
  output logic [NUM_ENGINES*CSA_CALC_IN_WIDTH-1:0]    eng_in,
  input  logic [NUM_ENGINES-1:0]                      eng_ready,
  input  logic [NUM_ENGINES*CSA_CALC_OUT_WIDTH-1:0]   eng_out,
  output logic [NUM_ENGINES-1:0]                      eng_reset,
  output logic [AXI_DATA_WIDTH-1:0]                   jobs_issued,
  output logic [AXI_DATA_WIDTH-1:0]                   jobs_done
);

  typedef enum logic {D_IDLE, D_ISSUE} d_state_e;
  typedef enum logic {C_SCAN, C_HOLD} c_state_e;

  localparam logic [ENG_IDX_WIDTH-1:0] LAST_IDX = ENG_IDX_WIDTH'(NUM_ENGINES - 1);

  if (NUM_ENGINES < 2 || NUM_ENGINES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("csa_calc_dispatcher: parameter out of range");
  end

  d_state_e d_state_q, d_state_d;
  c_state_e c_state_q, c_state_d;
  logic [NUM_ENGINES-1:0]                         busy_q, busy_d;
  logic [ENG_IDX_WIDTH-1:0]                       d_ptr_q, d_ptr_d, c_ptr_q, c_ptr_d;
  logic                                           job_ready_q, job_ready_d;
  logic                                           res_valid_q, res_valid_d;
  logic [CSA_CALC_OUT_WIDTH-1:0]                  res_data_q, res_data_d;
  logic [ENG_IDX_WIDTH-1:0]                       res_engine_q, res_engine_d;
  logic [NUM_ENGINES-1:0]                         eng_request_q, eng_request_d;
  logic [NUM_ENGINES-1:0]                         eng_reset_q, eng_reset_d;
  logic [NUM_ENGINES-1:0][AXI_DATA_WIDTH-1:0]     eng_times_q, eng_times_d;
  logic [NUM_ENGINES-1:0][AXI_DATA_WIDTH-1:0]     eng_delay_q, eng_delay_d;
  logic [NUM_ENGINES-1:0][CSA_CALC_IN_WIDTH-1:0]  eng_in_q, eng_in_d;
  logic [AXI_DATA_WIDTH-1:0]                      jobs_issued_q, jobs_issued_d;
  logic [AXI_DATA_WIDTH-1:0]                      jobs_done_q, jobs_done_d;

  logic [NUM_ENGINES-1:0]        free, done_mask;
  logic [ENG_IDX_WIDTH:0]        d_pick, c_pick;
  logic [CSA_CALC_OUT_WIDTH-1:0] c_out;
  logic                          c_rdy;

`ifdef CSA_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [NUM_ENGINES-1:0][WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [NUM_ENGINES-1:0]           wd_expired;
  logic                             res_timeout_q, res_timeout_d;
`endif

  // {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [ENG_IDX_WIDTH:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                                     input logic [ENG_IDX_WIDTH-1:0] ptr);
    logic                     found;
    logic [ENG_IDX_WIDTH-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!found && req[k] && ENG_IDX_WIDTH'(k) >= ptr) begin
        found = 1'b1;
        idx   = ENG_IDX_WIDTH'(k);
      end
    end
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = ENG_IDX_WIDTH'(k);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [ENG_IDX_WIDTH-1:0] next_idx(input logic [ENG_IDX_WIDTH-1:0] i);
    return (i == LAST_IDX) ? '0 : i + ENG_IDX_WIDTH'(1);
  endfunction

  always_comb begin
    free = ~busy_q & ~eng_inuse & ~eng_ready;

`ifdef CSA_DISPATCH_TIMEOUT_EN
    for (int k = 0; k < NUM_ENGINES; k++) begin
      wd_expired[k] = busy_q[k] && (wd_cnt_q[k] == WD_MAX);
      if (!busy_q[k] || eng_request_q[k])
        wd_cnt_d[k] = '0;
      else if (wd_expired[k])
        wd_cnt_d[k] = wd_cnt_q[k];
      else
        wd_cnt_d[k] = wd_cnt_q[k] + WD_W'(1);
    end
    done_mask     = busy_q & (eng_ready | wd_expired);
    res_timeout_d = res_timeout_q;
`else
    done_mask = busy_q & eng_ready;
`endif

    d_pick = rr_pick(free, d_ptr_q);
    c_pick = rr_pick(done_mask, c_ptr_q);
    c_out  = '0;
    c_rdy  = 1'b0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (c_pick[ENG_IDX_WIDTH-1:0] == ENG_IDX_WIDTH'(k)) begin
        c_out = eng_out[k*CSA_CALC_OUT_WIDTH +: CSA_CALC_OUT_WIDTH];
        c_rdy = eng_ready[k];
      end
    end

    d_state_d     = d_state_q;
    c_state_d     = c_state_q;
    busy_d        = busy_q;
    d_ptr_d       = d_ptr_q;
    c_ptr_d       = c_ptr_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_engine_d  = res_engine_q;
    eng_request_d = '0;
    eng_reset_d   = '0;
    eng_times_d   = eng_times_q;
    eng_delay_d   = eng_delay_q;
    eng_in_d      = eng_in_q;
    jobs_issued_d = jobs_issued_q;
    jobs_done_d   = jobs_done_q;

    case (d_state_q)
      D_IDLE: begin
        if (job_valid && job_ready_q && d_pick[ENG_IDX_WIDTH]) begin
          for (int k = 0; k < NUM_ENGINES; k++) begin
            if (d_pick[ENG_IDX_WIDTH-1:0] == ENG_IDX_WIDTH'(k)) begin
              busy_d[k]        = 1'b1;
              eng_in_d[k]      = job_in;
              eng_times_d[k]   = cfg_times;
              eng_delay_d[k]   = cfg_delay;
              eng_request_d[k] = 1'b1;
            end
          end
          d_ptr_d   = next_idx(d_pick[ENG_IDX_WIDTH-1:0]);
          d_state_d = D_ISSUE;
        end
      end
      D_ISSUE: begin
        jobs_issued_d = jobs_issued_q + AXI_DATA_WIDTH'(1);
        d_state_d     = D_IDLE;
      end
      default: d_state_d = D_IDLE;
    endcase

    case (c_state_q)
      C_SCAN: begin
        if (c_pick[ENG_IDX_WIDTH]) begin
          res_valid_d  = 1'b1;
          res_engine_d = c_pick[ENG_IDX_WIDTH-1:0];
          res_data_d   = c_out;
`ifdef CSA_DISPATCH_TIMEOUT_EN
          // A real result seen in the same cycle as expiry takes precedence.
          res_timeout_d = !c_rdy;
          if (!c_rdy) res_data_d = '0;
`endif
          c_state_d = C_HOLD;
        end
      end
      C_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          for (int k = 0; k < NUM_ENGINES; k++) begin
            if (res_engine_q == ENG_IDX_WIDTH'(k)) begin
              eng_reset_d[k] = 1'b1;
              busy_d[k]      = 1'b0;
            end
          end
          jobs_done_d = jobs_done_q + AXI_DATA_WIDTH'(1);
          c_ptr_d     = next_idx(res_engine_q);
          c_state_d   = C_SCAN;
        end
      end
      default: c_state_d = C_SCAN;
    endcase

    // An engine whose ready is still high after release is not yet free.
    job_ready_d = (d_state_d == D_IDLE) && |(~busy_d & ~eng_inuse & ~eng_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_state_q     <= D_IDLE;
      c_state_q     <= C_SCAN;
      busy_q        <= '0;
      d_ptr_q       <= '0;
      c_ptr_q       <= '0;
      job_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_engine_q  <= '0;
      eng_request_q <= '0;
      eng_reset_q   <= '0;
      eng_times_q   <= '0;
      eng_delay_q   <= '0;
      eng_in_q      <= '0;
      jobs_issued_q <= '0;
      jobs_done_q   <= '0;
`ifdef CSA_DISPATCH_TIMEOUT_EN
      wd_cnt_q      <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      d_state_q     <= d_state_d;
      c_state_q     <= c_state_d;
      busy_q        <= busy_d;
      d_ptr_q       <= d_ptr_d;
      c_ptr_q       <= c_ptr_d;
      job_ready_q   <= job_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_engine_q  <= res_engine_d;
      eng_request_q <= eng_request_d;
      eng_reset_q   <= eng_reset_d;
      eng_times_q   <= eng_times_d;
      eng_delay_q   <= eng_delay_d;
      eng_in_q      <= eng_in_d;
      jobs_issued_q <= jobs_issued_d;
      jobs_done_q   <= jobs_done_d;
`ifdef CSA_DISPATCH_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  assign job_ready   = job_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_engine  = res_engine_q;
  assign eng_request = eng_request_q;
  assign eng_reset   = eng_reset_q;
  assign eng_times   = eng_times_q;
  assign eng_delay   = eng_delay_q;
  assign eng_in      = eng_in_q;
  assign jobs_issued = jobs_issued_q;
  assign jobs_done   = jobs_done_q;
`ifdef CSA_DISPATCH_TIMEOUT_EN
  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_csa_calc_dispatcher.sv
// tb/tb_csa_calc_dispatcher.sv - directed self-checking bench for csa_calc_dispatcher.
module tb_csa_calc_dispatcher;
  localparam int AW = 32;
  localparam int IW = 40;
  localparam int OW = 48;
  localparam int N  = 4;
  localparam int EW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   cfg_times, cfg_delay;
  logic            job_valid, job_ready;
  logic [IW-1:0]   job_in;
  logic            res_valid, res_ready;
  logic [OW-1:0]   res_data;
  logic [EW-1:0]   res_engine;
  logic            res_timeout;
  logic [N-1:0]    eng_inuse, eng_request, eng_ready, eng_reset;
  logic [N*AW-1:0] eng_times, eng_delay;
  logic [N*IW-1:0] eng_in;
  logic [N*OW-1:0] eng_out;
  logic [AW-1:0]   jobs_issued, jobs_done;

  logic [IW-1:0]   cap [N];
  int              lat [N];
  int              cnt [N];
  int              req_cycles [N];
  int              rst_cycles;
  logic [N-1:0]    auto_rdy, man_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_calc_dispatcher #(
    .AXI_DATA_WIDTH(AW), .CSA_CALC_IN_WIDTH(IW), .CSA_CALC_OUT_WIDTH(OW),
    .NUM_ENGINES(N), .ENG_IDX_WIDTH(EW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_times(cfg_times), .cfg_delay(cfg_delay),
    .job_valid(job_valid), .job_ready(job_ready), .job_in(job_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_engine(res_engine), .res_timeout(res_timeout), .eng_inuse(eng_inuse),
    .eng_request(eng_request), .eng_times(eng_times), .eng_delay(eng_delay),
    .eng_in(eng_in), .eng_ready(eng_ready), .eng_out(eng_out), .eng_reset(eng_reset),
    .jobs_issued(jobs_issued), .jobs_done(jobs_done)
  );

  assign eng_ready = auto_rdy | man_rdy;
  for (genvar g = 0; g < N; g++) begin : g_eng
    assign eng_out[g*OW +: OW] = {4'(g), 4'hA, cap[g]};
  end

  // Engine stand-in: captures its input on request, raises ready lat cycles later (lat 0 = never).
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (eng_request[k]) req_cycles[k]++;
      if (eng_reset[k]) rst_cycles++;
      if (!rst_n) begin
        auto_rdy[k] = 1'b0;
        cnt[k]      = 0;
        cap[k]      = '0;
      end else if (eng_reset[k]) begin
        auto_rdy[k] = 1'b0;
        cnt[k]      = 0;
      end else if (eng_request[k]) begin
        cap[k] = eng_in[k*IW +: IW];
        cnt[k] = lat[k];
      end else if (cnt[k] != 0) begin
        cnt[k]--;
        if (cnt[k] == 0) auto_rdy[k] = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] exp_out(input int e, input logic [IW-1:0] d);
    return {e[3:0], 4'hA, d};
  endfunction

  task automatic send_job(input logic [IW-1:0] din, input int eng);
    int n;
    n         = 0;
    job_in    = din;
    cfg_times = din[31:0] ^ 32'h5555_0000;
    cfg_delay = din[39:8];
    job_valid = 1'b1;
    while (!job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("job_accept_seen", job_ready, 1);
    @(negedge clk);
    job_valid = 1'b0;
    check("req_onehot", eng_request, 64'(1) << eng);
    check("slot_in", eng_in[eng*IW +: IW], din);
    check("slot_times", eng_times[eng*AW +: AW], din[31:0] ^ 32'h5555_0000);
    check("slot_delay", eng_delay[eng*AW +: AW], din[39:8]);
  endtask

  task automatic wait_res(input int maxc);
    int n;
    n = 0;
    while (!res_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  task automatic do_reset();
    int n;
    rst_n     = 1'b0;
    job_valid = 1'b0;
    res_ready = 1'b0;
    man_rdy   = '0;
    eng_inuse = '0;
    for (int k = 0; k < N; k++) lat[k] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!job_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_reset", job_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int rbase;
    logic [OW-1:0] snap;
    job_valid = 1'b0; job_in = '0; cfg_times = '0; cfg_delay = '0;
    res_ready = 1'b0; eng_inuse = '0; man_rdy = '0;
    for (int k = 0; k < N; k++) lat[k] = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_eng_request", eng_request, 0);
    check("rst_eng_reset", eng_reset, 0);
    check("rst_jobs_issued", jobs_issued, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_eng_in", 64'(|eng_in), 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_timeout", res_timeout, 0);

    // Single job on engine 0, ready 10 cycles after its request.
    do_reset();
    lat[0] = 10;
    res_ready = 1'b1;
    send_job(40'h11_1111_1111, 0);
    wait_res(40);
    check("single_res_data", res_data, exp_out(0, 40'h11_1111_1111));
    check("single_res_engine", res_engine, 0);
    check("single_res_timeout", res_timeout, 0);
    @(negedge clk);
    check("single_eng_reset", eng_reset, 4'b0001);
    check("single_res_valid_drop", res_valid, 0);
    @(negedge clk);
    check("single_eng_reset_1cyc", eng_reset, 4'b0000);
    check("single_jobs_issued", jobs_issued, 1);
    check("single_jobs_done", jobs_done, 1);
    check("single_req_1cyc", req_cycles[0], 1);

    // Round-robin fill, fifth job waits until engine 2 is released.
    do_reset();
    send_job(40'h00_0000_00A0, 0);
    send_job(40'h00_0000_00A1, 1);
    send_job(40'h00_0000_00A2, 2);
    send_job(40'h00_0000_00A3, 3);
    repeat (3) @(negedge clk);
    check("fill_job_ready_low", job_ready, 0);
    check("fill_req3_1cyc", req_cycles[3], 1);
    fork
      send_job(40'h00_0000_00A4, 2);
      begin
        repeat (6) @(negedge clk);
        check("fill_fifth_blocked", jobs_issued, 4);
        res_ready  = 1'b1;
        man_rdy[2] = 1'b1;
        wait_res(20);
        check("fill_res_engine", res_engine, 2);
        check("fill_res_data", res_data, exp_out(2, 40'h00_0000_00A2));
        @(negedge clk);
        check("fill_eng_reset", eng_reset, 4'b0100);
        man_rdy[2] = 1'b0;
      end
    join
    @(negedge clk);
    check("fill_jobs_issued", jobs_issued, 5);

    // Back-pressure: engines 1 and 2 finish together, consumer stalls 20 cycles.
    do_reset();
    send_job(40'h00_0000_00B0, 0);
    send_job(40'h00_0000_00B1, 1);
    send_job(40'h00_0000_00B2, 2);
    @(negedge clk);
    man_rdy = 4'b0110;
    wait_res(10);
    check("bp_first_engine", res_engine, 1);
    check("bp_first_data", res_data, exp_out(1, 40'h00_0000_00B1));
    snap = res_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_data !== snap || res_engine !== 4'd1 || eng_reset !== 4'b0000) bad++;
    end
    check("bp_stable", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_reset1", eng_reset, 4'b0010);
    wait_res(10);
    check("bp_second_engine", res_engine, 2);
    check("bp_second_data", res_data, exp_out(2, 40'h00_0000_00B2));
    @(negedge clk);
    check("bp_reset2", eng_reset, 4'b0100);
    check("bp_jobs_done", jobs_done, 2);

    // Re-dispatch guard: engine 0 holds ready for 3 cycles after its release.
    do_reset();
    eng_inuse = 4'b1110;
    res_ready = 1'b1;
    send_job(40'h00_0000_00C0, 0);
    man_rdy[0] = 1'b1;
    wait_res(10);
    @(negedge clk);
    check("guard_eng_reset", eng_reset, 4'b0001);
    job_in    = 40'h00_0000_00C1;
    job_valid = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (job_ready || eng_request[0]) bad++;
    end
    check("guard_hold", bad, 0);
    man_rdy[0] = 1'b0;
    send_job(40'h00_0000_00C1, 0);

    // Reset while three engines are busy and a result is pending.
    do_reset();
    send_job(40'h00_0000_00D0, 0);
    send_job(40'h00_0000_00D1, 1);
    send_job(40'h00_0000_00D2, 2);
    man_rdy[0] = 1'b1;
    wait_res(10);
    rbase = rst_cycles;
    rst_n = 1'b0;
    @(negedge clk);
    man_rdy = '0;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_job_ready", job_ready, 0);
    check("mid_rst_jobs_issued", jobs_issued, 0);
    check("mid_rst_eng_in", 64'(|eng_in), 0);
    check("mid_rst_eng_times", 64'(|eng_times), 0);
    check("mid_rst_res_data", res_data, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_release", rst_cycles, rbase);
    check("mid_rst_ready_back", job_ready, 1);
    check("mid_rst_res_idle", res_valid, 0);

`ifdef CSA_DISPATCH_TIMEOUT_EN
    // Watchdog: engine 3 never finishes.
    do_reset();
    eng_inuse = 4'b0111;
    res_ready = 1'b1;
    send_job(40'h00_0000_00E3, 3);
    wait_res(60);
    check("to_res_timeout", res_timeout, 1);
    check("to_res_data", res_data, 0);
    check("to_res_engine", res_engine, 3);
    @(negedge clk);
    check("to_eng_reset", eng_reset, 4'b1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
